// File: rtl/rv32i_multicycle_controller_if.sv
// rv32i_multicycle_controller_if: ALU operation encoding and the controller/datapath signal bundle
package alu_types;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_control_t;
endpackage

interface rv32i_multicycle_controller_if;
  import alu_types::*;
  logic ena;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7_5;
  logic zero;
  logic alu_lsb;
  logic pc_write;
  logic ir_write;
  logic mem_write;
  logic reg_write;
  logic adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] res_src;
  logic [2:0] imm_src;
  alu_control_t alu_control;
  logic [3:0] state_o;
  logic halted;
  modport slave(
    input ena, op, funct3, funct7_5, zero, alu_lsb,
    output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
      res_src, imm_src, alu_control, state_o, halted
  );
  modport master(
    output ena, op, funct3, funct7_5, zero, alu_lsb,
    input pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
      res_src, imm_src, alu_control, state_o, halted
  );
endinterface

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller: main control FSM plus ALU and immediate decode for the multicycle rv32i datapath
module rv32i_multicycle_controller
  import alu_types::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1
) (
  input logic clk,
  input logic rst,
  rv32i_multicycle_controller_if.slave c
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXR, S_EXI,
    S_ALUWB, S_BR, S_JAL, S_JALR, S_LINK, S_LUI, S_HALT
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_R = 7'h33, OP_I = 7'h13,
    OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  state_t state, next;
  logic pcw, irw, mw, rw, taken;
  alu_control_t funct_op, br_op;
  always_ff @(posedge clk) state <= rst ? S_FETCH : c.ena ? next : state;
  always_comb begin
    funct_op = ALU_AND;
    case (c.funct3)
      3'd0: funct_op = (c.op == OP_R && c.funct7_5) ? ALU_SUB : ALU_ADD;
      3'd1: funct_op = ALU_SLL;
      3'd2: funct_op = ALU_SLT;
      3'd3: funct_op = ALU_SLTU;
      3'd4: funct_op = ALU_XOR;
      3'd5: funct_op = c.funct7_5 ? ALU_SRA : ALU_SRL;
      3'd6: funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
  end
  // signed/unsigned compares leave their outcome in bit 0; funct3[0] inverts the sense
  assign br_op = !c.funct3[2] ? ALU_SUB : c.funct3[1] ? ALU_SLTU : ALU_SLT;
  assign taken = c.funct3[2] ? c.alu_lsb ^ c.funct3[0] : c.zero ^ c.funct3[0];
  assign c.imm_src = c.op == OP_STORE ? 3'b001 : c.op == OP_BR ? 3'b010 : c.op == OP_JAL ? 3'b011 :
    (c.op == OP_LUI || c.op == OP_AUIPC) ? 3'b100 : 3'b000;
  always_comb begin
    next = state;
    pcw = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    c.adr_src = 1'b0;
    c.alu_src_a = 2'b00;
    c.alu_src_b = 2'b10;
    c.res_src = 2'b00;
    c.alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        irw = 1'b1;
        pcw = 1'b1;
        c.res_src = 2'b10;
        next = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        case (c.op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R: next = S_EXR;
          OP_I: next = S_EXI;
          OP_BR: next = S_BR;
          OP_JAL: next = S_JAL;
          OP_JALR: next = S_JALR;
          OP_LUI: next = S_LUI;
          OP_AUIPC: next = S_ALUWB;
          default: next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        next = c.op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.adr_src = 1'b1;
        next = S_MEMWB;
      end
      S_MEMWB: begin
        c.res_src = 2'b01;
        rw = 1'b1;
        next = S_FETCH;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        mw = 1'b1;
        next = S_FETCH;
      end
      S_EXR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_control = funct_op;
        next = S_ALUWB;
      end
      S_EXI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_control = funct_op;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1;
        next = S_FETCH;
      end
      S_BR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_control = br_op;
        pcw = taken;
        next = S_FETCH;
      end
      S_JAL: begin
        pcw = 1'b1;
        c.alu_src_a = 2'b01;
        next = S_ALUWB;
      end
      S_JALR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.res_src = 2'b10;
        pcw = 1'b1;
        next = S_LINK;
      end
      S_LINK: begin
        c.alu_src_a = 2'b01;
        next = S_ALUWB;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
        next = S_ALUWB;
      end
      default: next = S_HALT;
    endcase
  end
  assign c.pc_write = pcw & c.ena & !rst;
  assign c.ir_write = irw & c.ena & !rst;
  assign c.mem_write = mw & c.ena & !rst;
  assign c.reg_write = rw & c.ena & !rst;
  assign c.halted = state == S_HALT && !rst;
  assign c.state_o = state;
endmodule
